// File: rtl/sseg_scan_mux.sv
// Time-multiplexed scanner for a common-anode 7-segment display with frame-synchronous
// value commit, per-slot blanking gap and optional leading-zero blanking.
module sseg_scan_mux #(
   parameter int unsigned NDIG      = 3,
   parameter int unsigned TICK_DIV  = 3000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic [4*NDIG-1:0]    value,
   input  logic [NDIG-1:0]      dp_in,
   input  logic                 lzb_en,
   output logic [3:0]           hex,
   output logic                 dp,
   output logic [NDIG-1:0]      an,
   output logic                 frame_done
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned VW = 4 * NDIG;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

   logic [TW-1:0]   tick_q, tick_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [VW-1:0]   disp_q, disp_d;
   logic [NDIG-1:0] disp_dp_q, disp_dp_d;
   logic [VW-1:0]   pend_q, pend_d;
   logic [NDIG-1:0] pend_dp_q, pend_dp_d;
   logic            pend_vld_q, pend_vld_d;
   logic [3:0]      hex_q, hex_d;
   logic            dp_q, dp_d;
   logic [NDIG-1:0] an_q, an_d;
   logic            frame_done_q, frame_done_d;
   logic            slot_last;
   logic            upper_zero;

   // Outputs are computed from the current slot position and the post-commit display
   // value, so the registered outputs line up with the scan position of each cycle.
   always_comb begin
      tick_d       = tick_q;
      idx_d        = idx_q;
      disp_d       = disp_q;
      disp_dp_d    = disp_dp_q;
      pend_d       = pend_q;
      pend_dp_d    = pend_dp_q;
      pend_vld_d   = pend_vld_q;
      hex_d        = 4'h0;
      dp_d         = 1'b0;
      an_d         = '1;
      frame_done_d = 1'b0;
      upper_zero   = 1'b1;

      slot_last = (tick_q == TICK_LAST);
      tick_d    = slot_last ? '0 : tick_q + TW'(1);
      if (slot_last) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end

      // Commit only at the start of a digit-0 slot so a frame never mixes two values.
      if (tick_q == '0 && idx_q == '0 && pend_vld_q) begin
         disp_d     = pend_q;
         disp_dp_d  = pend_dp_q;
         pend_vld_d = 1'b0;
      end

      if (load) begin
         pend_d     = value;
         pend_dp_d  = dp_in;
         pend_vld_d = 1'b1;
      end

      // Scan from the top digit down so upper_zero covers digits i..NDIG-1.
      for (int i = NDIG - 1; i >= 0; i--) begin
         upper_zero = upper_zero && (disp_d[4*i +: 4] == 4'h0) && !disp_dp_d[i];
         if (idx_q == IW'(i)) begin
            hex_d = disp_d[4*i +: 4];
            dp_d  = disp_dp_d[i];
            if (tick_q >= BLANK_END && !(lzb_en && (i > 0) && upper_zero)) begin
               an_d[i] = 1'b0;
            end
         end
      end

      frame_done_d = slot_last && (idx_q == IDX_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_q       <= '0;
         idx_q        <= '0;
         disp_q       <= '0;
         disp_dp_q    <= '0;
         pend_q       <= '0;
         pend_dp_q    <= '0;
         pend_vld_q   <= 1'b0;
         hex_q        <= 4'h0;
         dp_q         <= 1'b0;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         disp_dp_q    <= disp_dp_d;
         pend_q       <= pend_d;
         pend_dp_q    <= pend_dp_d;
         pend_vld_q   <= pend_vld_d;
         hex_q        <= hex_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign hex        = hex_q;
   assign dp         = dp_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed and randomized checks of sseg_scan_mux against a cycle-count based model
// (NDIG=3, TICK_DIV=8, BLANK_CYC=2).
module tb_sseg_scan_mux;

   localparam int unsigned NDIG = 3;
   localparam int unsigned TD   = 8;
   localparam int unsigned BC   = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load;
   logic [11:0] value;
   logic [2:0]  dp_in;
   logic        lzb_en;
   logic [3:0]  hex;
   logic        dp;
   logic [2:0]  an;
   logic        frame_done;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;

   logic [11:0] m_disp, m_pend;
   logic [2:0]  m_ddp, m_pdp;
   bit          m_pv;

   always #5 clk = ~clk;

   sseg_scan_mux #(.NDIG(NDIG), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .value      (value),
      .dp_in      (dp_in),
      .lzb_en     (lzb_en),
      .hex        (hex),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // Assert reset away from a clock edge, check it took effect at once, release before cycle 0.
   task automatic do_reset();
      reset_n = 1'b0;
      load    = 1'b0;
      lzb_en  = 1'b0;
      #1;
      check("rst_hex", 32'(hex), 32'h0);
      check("rst_dp", 32'(dp), 32'h0);
      check("rst_an", 32'(an), 32'h7);
      check("rst_fd", 32'(frame_done), 32'h0);
      cyc    = 0;
      m_disp = '0;
      m_ddp  = '0;
      m_pend = '0;
      m_pdp  = '0;
      m_pv   = 1'b0;
      @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   // One cycle: drive inputs, update the model, then compare outputs after the edge.
   task automatic step(input bit ld, input logic [11:0] v, input logic [2:0] d, input bit lz);
      int unsigned tick, idx;
      logic [3:0]  hex_e;
      logic        dp_e;
      logic [2:0]  an_e;
      bit          fd_e;
      load   = ld;
      value  = v;
      dp_in  = d;
      lzb_en = lz;
      tick = cyc % TD;
      idx  = (cyc / TD) % NDIG;
      if (tick == 0 && idx == 0 && cyc != 0 && m_pv) begin
         m_disp = m_pend;
         m_ddp  = m_pdp;
         m_pv   = 1'b0;
      end
      if (ld) begin
         m_pend = v;
         m_pdp  = d;
         m_pv   = 1'b1;
      end
      hex_e = 4'(m_disp >> (4 * idx));
      dp_e  = m_ddp[idx];
      an_e  = 3'b111;
      if (tick >= BC && !(lz && idx > 0 && (m_disp >> (4 * idx)) == 12'h0
                          && (m_ddp >> idx) == 3'b000)) begin
         an_e[idx] = 1'b0;
      end
      fd_e = (cyc % (NDIG * TD)) == (NDIG * TD - 1);
      @(posedge clk);
      #1;
      check("hex", 32'(hex), 32'(hex_e));
      check("dp", 32'(dp), 32'(dp_e));
      check("an", 32'(an), 32'(an_e));
      check("frame_done", 32'(frame_done), 32'(fd_e));
      check("an_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
      load = 1'b0;
      cyc++;
   endtask

   task automatic idle_to(input int unsigned target, input bit lz);
      while (cyc < target) step(1'b0, 12'($urandom), 3'($urandom), lz);
   endtask

   initial begin
      bit          ld, lz;
      logic [11:0] v;
      logic [2:0]  d;

      reset_n = 1'b1;
      load    = 1'b0;
      value   = '0;
      dp_in   = '0;
      lzb_en  = 1'b0;
      #3;
      do_reset();

      // Idle scan with a load mid-frame that must wait for the frame boundary.
      idle_to(5, 1'b0);
      step(1'b1, 12'h3A5, 3'b010, 1'b0);
      idle_to(24, 1'b0);
      check("t1_fd23", 32'(frame_done), 32'h1);
      check("t2_hex_pre", 32'(hex), 32'h0);
      idle_to(25, 1'b0);
      check("t2_hex24", 32'(hex), 32'h5);
      check("t2_dp24", 32'(dp), 32'h0);
      idle_to(33, 1'b0);
      check("t2_hex32", 32'(hex), 32'hA);
      check("t2_dp32", 32'(dp), 32'h1);
      idle_to(41, 1'b0);
      check("t2_hex40", 32'(hex), 32'h3);
      idle_to(48, 1'b0);

      // Leading-zero blanking.
      step(1'b1, 12'h007, 3'b000, 1'b1);
      idle_to(84, 1'b1);
      check("t3_an_d1", 32'(an), 32'h7);
      idle_to(92, 1'b1);
      check("t3_an_d2", 32'(an), 32'h7);
      idle_to(100, 1'b1);
      check("t3_an_d0", 32'(an), 32'h6);
      check("t3_hex_d0", 32'(hex), 32'h7);
      step(1'b1, 12'h000, 3'b000, 1'b1);
      idle_to(124, 1'b1);
      check("t3_zero_an", 32'(an), 32'h6);
      check("t3_zero_hex", 32'(hex), 32'h0);
      step(1'b1, 12'h000, 3'b100, 1'b1);
      idle_to(156, 1'b1);
      check("t3_dp_an_d1", 32'(an), 32'h5);
      idle_to(164, 1'b1);
      check("t3_dp_an_d2", 32'(an), 32'h3);

      // Load on the cycle before and on the commit edge.
      idle_to(167, 1'b0);
      step(1'b1, 12'h111, 3'b000, 1'b0);
      step(1'b1, 12'h222, 3'b000, 1'b0);
      idle_to(172, 1'b0);
      check("t4_hex_f1", 32'(hex), 32'h1);
      idle_to(180, 1'b0);
      check("t4_hex_f1d1", 32'(hex), 32'h1);
      idle_to(196, 1'b0);
      check("t4_hex_f2", 32'(hex), 32'h2);

      // Reset mid-frame with a pending load.
      step(1'b1, 12'h999, 3'b111, 1'b0);
      idle_to(205, 1'b0);
      do_reset();
      idle_to(48, 1'b0);
      check("t5_no_old_pend", 32'(hex), 32'h0);

      // Randomized loads and lzb_en toggling.
      lz = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         ld = ($urandom_range(15) == 0);
         v  = 12'($urandom);
         case ($urandom_range(3))
            0: v = v & 12'h00F;
            1: v = v & 12'h0FF;
            2: v = v & 12'h0F0;
            default: ;
         endcase
         d = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000;
         if ($urandom_range(63) == 0) lz = ~lz;
         step(ld, v, d, lz);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
